// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall/flush and forwarding control for the 5-stage pipeline.
// Shadows EX/MEM/WB control fields and counts stall and flush cycles.
module pipeline_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int XLEN_RA = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [XLEN_RA-1:0] id_rs1,
    input  logic [XLEN_RA-1:0] id_rs2,
    input  logic [XLEN_RA-1:0] id_rd,
    input  logic               dmem_busy,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               pipe_en,
    output logic               ex_jump,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic d_rw, d_ld, d_jmp, d_u1, d_u2;

    logic               ex_v, ex_rw, ex_ld, ex_jmp;
    logic [XLEN_RA-1:0] ex_rd, ex_rs1, ex_rs2;
    logic               mem_v, mem_rw, mem_ld;
    logic [XLEN_RA-1:0] mem_rd;
    logic               wb_v, wb_rw;
    logic [XLEN_RA-1:0] wb_rd;

    logic freeze, jump, lu, bubble;
    logic stall_inc, flush_inc;

    always_comb begin
        d_rw  = 1'b0;
        d_ld  = 1'b0;
        d_jmp = 1'b0;
        d_u1  = 1'b0;
        d_u2  = 1'b0;
        unique case (1'b1)
            (id_opcode == OP_R): begin
                d_rw = 1'b1;
                d_u1 = 1'b1;
                d_u2 = 1'b1;
            end
            (id_opcode == OP_I): begin
                d_rw = 1'b1;
                d_u1 = 1'b1;
            end
            (id_opcode == OP_LD): begin
                d_rw = 1'b1;
                d_ld = 1'b1;
                d_u1 = 1'b1;
            end
            (id_opcode == OP_ST): begin
                d_u1 = 1'b1;
                d_u2 = 1'b1;
            end
            (id_opcode == OP_JAL): begin
                d_rw  = 1'b1;
                d_jmp = 1'b1;
            end
            default: ;
        endcase
    end

    assign freeze = dmem_busy;
    assign jump   = ex_v & ex_jmp;
    assign lu     = ex_v & ex_ld & (ex_rd != '0) & id_valid
                  & ((d_u1 & (id_rs1 == ex_rd))
                  |  (d_u2 & (id_rs2 == ex_rd)));
    assign bubble    = jump | lu;
    assign stall_inc = freeze | (~jump & lu);
    assign flush_inc = ~freeze & jump;

    // MEM wins over WB; loads in MEM have no data yet, x0 never forwards
    function automatic logic [1:0] fsel(input logic [XLEN_RA-1:0] rs);
        if (!ex_v)
            return 2'b00;
        if (mem_v && mem_rw && !mem_ld && mem_rd != '0 && mem_rd == rs)
            return 2'b10;
        if (wb_v && wb_rw && wb_rd != '0 && wb_rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b0;
        ex_jump    = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            fwd_a = fsel(ex_rs1);
            fwd_b = fsel(ex_rs2);
            if (freeze) begin
                pc_en = 1'b0;
            end else if (jump) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                pipe_en    = 1'b1;
                ex_jump    = 1'b1;
            end else if (lu) begin
                idex_flush = 1'b1;
                pipe_en    = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                pipe_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v      <= 1'b0;
            mem_v     <= 1'b0;
            wb_v      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!freeze) begin
                wb_v   <= mem_v;
                wb_rd  <= mem_rd;
                wb_rw  <= mem_rw;
                mem_v  <= ex_v;
                mem_rd <= ex_rd;
                mem_rw <= ex_rw;
                mem_ld <= ex_ld;
                ex_v   <= bubble ? 1'b0 : id_valid;
                ex_rw  <= bubble ? 1'b0 : d_rw;
                ex_ld  <= bubble ? 1'b0 : d_ld;
                ex_jmp <= bubble ? 1'b0 : d_jmp;
                ex_rd  <= id_rd;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
            end
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random checks of pipeline_hazard_ctrl against an
// instruction-level pipeline model; a 2-bit-counter copy checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       dmem_busy = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, ex_jump;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush;
    logic        s_pipe_en, s_ex_jump;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .dmem_busy(dmem_busy), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_en(pipe_en), .ex_jump(ex_jump), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .dmem_busy(dmem_busy), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .pipe_en(s_pipe_en), .ex_jump(s_ex_jump), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   m_stall, m_flush, m_stall2, m_flush2;
    int   nchk = 0, npass = 0;

    function automatic bit f_rw(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_JAL};
    endfunction
    function automatic bit f_u1(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LD, OP_ST};
    endfunction
    function automatic bit f_u2(input logic [6:0] op);
        return op inside {OP_R, OP_ST};
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!m_ex.v) return 2'b00;
        if (m_mem.v && f_rw(m_mem.op) && m_mem.op != OP_LD
            && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.v && f_rw(m_wb.op) && m_wb.rd != 0 && m_wb.rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_jump();
        return m_ex.v && m_ex.op == OP_JAL;
    endfunction

    function automatic bit m_lu();
        return m_ex.v && m_ex.op == OP_LD && m_ex.rd != 0 && id_valid
            && ((f_u1(id_opcode) && id_rs1 == m_ex.rd)
            ||  (f_u2(id_opcode) && id_rs2 == m_ex.rd));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present inputs mid-cycle and compare every output with the model.
    task automatic drive(input logic r, input logic v, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] s1,
                         input logic [4:0] s2, input logic busy);
        logic [7:0] e;
        logic [1:0] fa, fb;
        @(negedge clk);
        rst = r; id_valid = v; id_opcode = op;
        id_rd = rd; id_rs1 = s1; id_rs2 = s2; dmem_busy = busy;
        #1;
        // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, ex_jump}
        fa = r ? 2'b00 : m_fwd(m_ex.rs1);
        fb = r ? 2'b00 : m_fwd(m_ex.rs2);
        if (r)            e = 8'b0011_0000;
        else if (busy)    e = 8'b0000_0000;
        else if (m_jump()) e = 8'b1111_1100;
        else if (m_lu())  e = 8'b0001_1000;
        else              e = 8'b1100_1000;
        chk("pc_en", pc_en, e[7]);
        chk("ifid_en", ifid_en, e[6]);
        chk("ifid_flush", ifid_flush, e[5]);
        chk("idex_flush", idex_flush, e[4]);
        chk("pipe_en", pipe_en, e[3]);
        chk("ex_jump", ex_jump, e[2]);
        chk("fwd_a", fwd_a, fa);
        chk("fwd_b", fwd_b, fb);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("sat_ctl", {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush,
                        s_pipe_en, s_ex_jump, s_fwd_a, s_fwd_b},
                       {e[7:2], fa, fb});
        chk("sat_stall", s_stall_cnt, m_stall2);
        chk("sat_flush", s_flush_cnt, m_flush2);
    endtask

    task automatic tick();
        bit j, l;
        j = m_jump();
        l = m_lu();
        @(posedge clk);
        if (rst) begin
            m_ex.v = 0; m_mem.v = 0; m_wb.v = 0;
            m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
        end else if (dmem_busy) begin
            m_stall  = (m_stall < 65535) ? m_stall + 1 : m_stall;
            m_stall2 = (m_stall2 < 3) ? m_stall2 + 1 : m_stall2;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (j) begin
                m_ex = '0;
                m_flush  = (m_flush < 65535) ? m_flush + 1 : m_flush;
                m_flush2 = (m_flush2 < 3) ? m_flush2 + 1 : m_flush2;
            end else if (l) begin
                m_ex = '0;
                m_stall  = (m_stall < 65535) ? m_stall + 1 : m_stall;
                m_stall2 = (m_stall2 < 3) ? m_stall2 + 1 : m_stall2;
            end else begin
                m_ex = '{v: id_valid, op: id_opcode, rd: id_rd,
                         rs1: id_rs1, rs2: id_rs2};
            end
        end
    endtask

    task automatic step(input logic v, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] s1,
                        input logic [4:0] s2, input logic busy);
        drive(1'b0, v, op, rd, s1, s2, busy);
        tick();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
            chk("rst_pc_en", pc_en, 1'b0);
            chk("rst_flush", {ifid_flush, idex_flush}, 2'b11);
            tick();
        end
    endtask

    logic [6:0] ops [7];

    initial begin
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_BR, 7'b0};
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;

        do_reset();
        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        chk("rel_pc_en", pc_en, 1'b1);
        chk("rel_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("rel_cnt", {stall_cnt, flush_cnt}, 32'd0);
        tick();

        step(1, OP_R, 5, 1, 2, 0);
        step(1, OP_R, 6, 5, 3, 0);
        drive(0, 0, '0, '0, '0, '0, 0);
        chk("b2b_fwd_a", fwd_a, 2'b10);
        tick();
        step(1, OP_R, 5, 1, 2, 0);
        step(1, OP_I, 9, 4, 0, 0);
        step(1, OP_R, 6, 5, 3, 0);
        drive(0, 0, '0, '0, '0, '0, 0);
        chk("gap_fwd_a", fwd_a, 2'b01);
        tick();

        do_reset();
        step(1, OP_LD, 7, 1, 0, 0);
        drive(0, 1, OP_R, 8, 7, 7, 0);
        chk("lu_stall", {pc_en, idex_flush}, 2'b01);
        tick();
        drive(0, 1, OP_R, 8, 7, 7, 0);
        chk("lu_once", {pc_en, idex_flush}, 2'b10);
        tick();
        drive(0, 0, '0, '0, '0, '0, 0);
        chk("lu_fwd", {fwd_a, fwd_b}, 4'b0101);
        chk("lu_cnt", stall_cnt, 16'd1);
        tick();

        do_reset();
        step(1, OP_LD, 7, 1, 0, 0);
        step(1, OP_JAL, 1, 0, 0, 0);
        drive(0, 1, OP_R, 8, 7, 7, 0);
        chk("jmp_ctl", {ex_jump, ifid_flush, idex_flush, pc_en}, 4'hf);
        tick();
        drive(0, 1, OP_R, 8, 7, 7, 0);
        chk("jmp_once", ex_jump, 1'b0);
        chk("jmp_cnt", {flush_cnt, stall_cnt}, {16'd1, 16'd0});
        tick();

        do_reset();
        step(1, OP_JAL, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, OP_R, 4, 2, 3, 1);
            chk("frz_ctl", {pc_en, pipe_en, ex_jump}, 3'b000);
            tick();
        end
        drive(0, 1, OP_R, 4, 2, 3, 0);
        chk("frz_redirect", ex_jump, 1'b1);
        chk("frz_cnt", stall_cnt, 16'd3);
        tick();

        do_reset();
        step(1, OP_I, 0, 1, 0, 0);
        step(1, OP_R, 2, 0, 0, 0);
        drive(0, 0, '0, '0, '0, '0, 0);
        chk("x0_fwd", {fwd_a, fwd_b}, 4'b0000);
        tick();
        for (int i = 0; i < 5; i++) step(0, '0, '0, '0, '0, 1);
        drive(0, 0, '0, '0, '0, '0, 0);
        chk("sat_cnt", {s_stall_cnt, stall_cnt}, {2'd3, 16'd5});
        tick();

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 4) != 0),
                  ops[$urandom_range(0, 6)],
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 5) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline: IF, ID, EX, MEM, WB.
- Keeps shadow copies of the EX, MEM and WB stage control fields and advances them in lockstep with the datapath pipeline registers.
- Produces stall, flush, redirect and forwarding-select controls.
- Sits beside the opcode decoder; it decodes RegWrite, load, store and jump locally from the ID-stage opcode.
- Also keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 16, width of each saturating performance counter.
- XLEN_RA, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  7  opcode of the ID instruction.
- id_rs1  in  XLEN_RA  rs1 of the ID instruction.
- id_rs2  in  XLEN_RA  rs2 of the ID instruction.
- id_rd  in  XLEN_RA  rd of the ID instruction.
- dmem_busy  in  1  MEM-stage data memory access not complete; freezes the pipe.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_flush  out  1  load a bubble into ID/EX.
- pipe_en  out  1  ID/EX, EX/MEM and MEM/WB load enable.
- ex_jump  out  1  redirect the PC to the EX-computed jal target.
- fwd_a  out  2  EX operand A select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  load-use plus freeze cycles, saturating.
- flush_cnt  out  CNT_W  jump flushes, saturating.

Behaviour:
- Local decode of id_opcode:
  - R-type 0110011: rw=1, uses rs1 and rs2.
  - I-type 0010011: rw=1, uses rs1.
  - Load 0000011: rw=1, ld=1, uses rs1.
  - Store 0100011: rw=0, uses rs1 and rs2.
  - jal 1101111: rw=1, jmp=1, uses neither.
  - Any other opcode: all flags 0.
- Shadow state:
  - EX: v, rd, rs1, rs2, rw, ld, jmp.
  - MEM: v, rd, rw, ld.
  - WB: v, rd, rw.
- Reset (rst=1 at an edge):
  - All v bits and both counters are set to 0.
  - While rst is high, outputs are forced to: pc_en=0, ifid_en=0, pipe_en=0, ifid_flush=1, idex_flush=1, ex_jump=0, fwd_a=fwd_b=00.
  - Reset asserted mid-stall or mid-jump discards all in-flight state.
- Combinational conditions:
  - freeze = dmem_busy.
  - jump = EX.v & EX.jmp.
  - lu (load-use) = EX.v & EX.ld & EX.rd≠0 & id_valid & ((uses_rs1 & id_rs1==EX.rd) | (uses_rs2 & id_rs2==EX.rd)).
- Priority is freeze > jump > lu > normal. Each case, per cycle:
  - freeze: pc_en=0, ifid_en=0, pipe_en=0, no flushes, ex_jump=0, shadow state holds, stall_cnt +1.
  - jump: pc_en=1, ex_jump=1, ifid_flush=1, idex_flush=1, pipe_en=1, flush_cnt +1. EX←bubble, MEM←EX, WB←MEM. A load-use condition with the wrong-path ID instruction is ignored.
  - lu: pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1, stall_cnt +1. EX←bubble, MEM←EX, WB←MEM. Exactly one bubble is inserted.
  - normal: pc_en=1, ifid_en=1, pipe_en=1. EX←ID decode (v=id_valid), MEM←EX, WB←MEM.
- Forwarding selects (fwd_a uses EX.rs1, fwd_b uses EX.rs2) are valid only when EX.v:
  - 10 if MEM.v & MEM.rw & ~MEM.ld & MEM.rd≠0 & MEM.rd==rs.
  - Else 01 if WB.v & WB.rw & WB.rd≠0 & WB.rd==rs.
  - Else 00.
  - MEM has priority over WB.
  - x0 is never forwarded.
  - Selects remain valid during a freeze.
- Counters saturate at 2^CNT_W−1 and never wrap.

Test Plan:
- Reset: hold rst for 2 cycles, then release with id_valid=0 → during reset pc_en=0 and both flushes=1; after release pc_en=1, fwd_a=fwd_b=00, both counters 0.
- Back-to-back ALU: add x5,x1,x2 then add x6,x5,x3 → fwd_a=10 on the second instruction's EX cycle; with one unrelated instruction between them, fwd_a=01.
- Load-use: lw x7 then add x8,x7,x7 → exactly 1 cycle with pc_en=0 and idex_flush=1; next cycle fwd_a=fwd_b=01; stall_cnt=1.
- Jump: jal x1 enters EX → single cycle with ex_jump=1, ifid_flush=1, idex_flush=1; flush_cnt=1. If the ID instruction uses rd of a load in MEM, no stall is taken.
- Freeze: dmem_busy=1 for 3 cycles while a jal is in EX → pc_en=pipe_en=0 and ex_jump=0 for all 3 cycles; redirect happens on the first cycle after busy drops; stall_cnt=3.
- x0 and saturation: addi x0 followed by an instruction reading x0 → fwd=00. With CNT_W=2, 5 stall cycles → stall_cnt=3.
